vcve2_vrf_seq: RTL and testbench
================================

// Module: vcve2_vrf_seq
// PURPOSE
//  Sequencer for element-wise vector ops on the memory-mapped VRF. It accepts one decoded vector
//  instruction and drives the vector AGU control lines (load/get_rs1/get_rs2/get_rd/incr).
//  It runs the word-by-word read-rs1 / read-rs2 / write-rd loop over an OBI-style data port.
//  It presents operands to the vector ALU and writes the ALU result back.
//  It sits between the vector decoder and the VRF memory port, alongside the AGU.
// PARAMETERS
//  MaxWords  8   max 32-bit words per vector register (VLEN/32); counter width = $clog2(MaxWords+1)
//  DataWidth 32  memory/operand data width
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, asynchronous, active-low
//  instr_valid_i  in   1          decoder offers instruction
//  instr_ready_o  out  1          sequencer accepts (high only in IDLE)
//  use_rs1_i      in   1          op reads vs1
//  use_rs2_i      in   1          op reads vs2
//  vl_words_i     in   CW         words to process (0..MaxWords)
//  agu_load_o     out  1          AGU parallel load of rs1/rs2/rd counters
//  agu_get_rs1_o  out  1          select rs1 address (one-hot with rs2/rd)
//  agu_get_rs2_o  out  1          select rs2 address
//  agu_get_rd_o   out  1          select rd address
//  agu_incr_o     out  1          advance selected AGU counter
//  mem_req_o      out  1          memory request
//  mem_we_o       out  1          1 = write
//  mem_gnt_i      in   1          request granted
//  mem_rvalid_i   in   1          read data valid
//  mem_rdata_i    in   DataWidth  read data
//  mem_wdata_o    out  DataWidth  write data (= alu_result_i)
//  op_a_o         out  DataWidth  registered vs1 word
//  op_b_o         out  DataWidth  registered vs2 word
//  alu_result_i   in   DataWidth  combinational ALU result of op_a_o/op_b_o
//  busy_o         out  1          not IDLE
//  done_o         out  1          1-cycle pulse on completion
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except instr_ready_o=1; op_a/op_b, word counter cleared.
//  - Accept on instr_valid_i & instr_ready_o: latch use_rs1, use_rs2, vl_words.
//    use_rs1=use_rs2=0 is illegal (undefined).
//  - States: IDLE, LOAD, RD1, W1, RD2, W2, WR, DONE.
//  - IDLE -> LOAD on accept; vl_words=0 -> DONE directly (no AGU load, no memory traffic).
//  - LOAD: agu_load_o=1 for exactly 1 cycle -> RD1 if use_rs1, else RD2.
//  - RD1: req=1, we=0, get_rs1=1; hold req/addr until gnt.
//    On gnt: incr=1 -> W1.
//  - W1: wait rvalid (earliest 1 cycle after gnt); capture op_a.
//    -> RD2 if use_rs2, else WR.
//  - RD2/W2: same as RD1/W1 with get_rs2; capture op_b -> WR.
//  - WR: req=1, we=1, get_rd=1, wdata=alu_result_i held stable until gnt.
//    On gnt: incr=1 and decrement counter.
//    -> DONE if counter reaches 0, else RD1/RD2 (first used source).
//  - DONE: done_o=1 for 1 cycle -> IDLE. Next instruction is acceptable only in the following cycle.
//  - Exactly one agu_get_* high in RD*/WR; all low elsewhere. agu_incr_o only on a gnt cycle.
//  - Operand not read keeps its previous value (op_b held when use_rs2=0).
//  - Single outstanding transaction; mem_req_o never dropped before gnt.
//    rvalid outside W1/W2 is ignored.
//  - Cycle count with gnt and rvalid at the earliest point:
//    1 (LOAD) + N*(1+2*use_rs1+2*use_rs2... i.e. 2 per used source +1 write) + 1 (DONE).
//  - Async reset mid-operation: immediate IDLE, req dropped, no done_o.
//    The AGU counters are reloaded on the next LOAD.
// TESTING
//  - vl=2, both srcs, gnt/rvalid at earliest: mem addr seq A1,A2,D,A1+4,A2+4,D+4.
//    done_o 12 cycles after accept.
//  - vl=1, use_rs2 only: single read of vs2 then write; op_a unchanged; done_o 5 cycles after accept.
//  - vl=0: no mem_req_o, no agu_load_o; done_o one cycle after accept.
//  - gnt delayed 3 cycles in RD1 and WR: req/addr/wdata stable, incr high only on gnt cycle.
//  - rvalid delayed 2 cycles, plus spurious rvalid in WR: op_a takes only the W1 data.
//  - rst_ni low during W2 of word 3 of 8: outputs at reset values at once.
//    A new instruction then restarts from the base addresses.

Source files
------------

// File: rtl/vcve2_vrf_seq.sv
// vcve2_vrf_seq
// Sequencer for element-wise vector operations on the memory-mapped VRF.
// It accepts one decoded instruction and steps through the vector one word at
// a time: read vs1, read vs2, write vd. Each source read that is not needed is
// skipped. It drives the AGU control strobes and the OBI-style data port, and
// it holds the operand words that feed the vector ALU.
//
// Handshakes:
//   instr:  an instruction transfers on a cycle where instr_valid_i and
//           instr_ready_o are both high. instr_ready_o is high only in IDLE.
//   mem:    a request transfers on a cycle where mem_req_o and mem_gnt_i are
//           both high. While mem_req_o is waiting for grant, it and all of its
//           attributes (we, AGU select, wdata) stay constant. Only one
//           transaction is outstanding at a time. Read data is taken only in
//           the wait state that follows a granted read, and mem_rvalid_i is
//           ignored in every other state.
module vcve2_vrf_seq #(
  parameter int unsigned MaxWords  = 8,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned CW       = $clog2(MaxWords + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic                 use_rs1_i,
  input  logic                 use_rs2_i,
  input  logic [CW-1:0]        vl_words_i,
  output logic                 agu_load_o,
  output logic                 agu_get_rs1_o,
  output logic                 agu_get_rs2_o,
  output logic                 agu_get_rd_o,
  output logic                 agu_incr_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [DataWidth-1:0] op_a_o,
  output logic [DataWidth-1:0] op_b_o,
  input  logic [DataWidth-1:0] alu_result_i,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RD1  = 3'd2,
    W1   = 3'd3,
    RD2  = 3'd4,
    W2   = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic                 use_rs1_q, use_rs1_d;
  logic                 use_rs2_q, use_rs2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DataWidth-1:0] op_a_q, op_a_d;
  logic [DataWidth-1:0] op_b_q, op_b_d;

  // Register the state, the latched instruction fields, the word counter and the operands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      use_rs1_q <= use_rs1_d;
      use_rs2_q <= use_rs2_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  // Compute the next state and the control outputs for the current state.
  always_comb begin
    state_d       = state_q;
    use_rs1_d     = use_rs1_q;
    use_rs2_d     = use_rs2_q;
    cnt_d         = cnt_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    instr_ready_o = 1'b0;
    agu_load_o    = 1'b0;
    agu_get_rs1_o = 1'b0;
    agu_get_rs2_o = 1'b0;
    agu_get_rd_o  = 1'b0;
    agu_incr_o    = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = '0;
    done_o        = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          use_rs1_d = use_rs1_i;
          use_rs2_d = use_rs2_i;
          cnt_d     = vl_words_i;
          // An empty vector finishes without touching the AGU or memory.
          state_d   = (vl_words_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        agu_load_o = 1'b1;
        state_d    = use_rs1_q ? RD1 : RD2;
      end
      RD1: begin
        mem_req_o     = 1'b1;
        agu_get_rs1_o = 1'b1;
        if (mem_gnt_i) begin
          agu_incr_o = 1'b1;
          state_d    = W1;
        end
      end
      W1: begin
        if (mem_rvalid_i) begin
          op_a_d  = mem_rdata_i;
          state_d = use_rs2_q ? RD2 : WR;
        end
      end
      RD2: begin
        mem_req_o     = 1'b1;
        agu_get_rs2_o = 1'b1;
        if (mem_gnt_i) begin
          agu_incr_o = 1'b1;
          state_d    = W2;
        end
      end
      W2: begin
        if (mem_rvalid_i) begin
          op_b_d  = mem_rdata_i;
          state_d = WR;
        end
      end
      WR: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        agu_get_rd_o = 1'b1;
        // The ALU result depends only on the registered operands, so it stays stable until grant.
        mem_wdata_o  = alu_result_i;
        if (mem_gnt_i) begin
          agu_incr_o = 1'b1;
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end else begin
            state_d = use_rs1_q ? RD1 : RD2;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign op_a_o = op_a_q;
  assign op_b_o = op_b_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_vcve2_vrf_seq.sv
// tb_vcve2_vrf_seq
// Bench for the VRF sequencer. The environment contains an AGU address model,
// a memory responder with configurable grant and read latency, and an adder
// that acts as the ALU. The expected address stream, write data, operands and
// completion latency are all derived from the instruction fields.
module tb_vcve2_vrf_seq;

  localparam int CW = 4;
  localparam int DW = 32;

  logic          clk_i;
  logic          rst_ni;
  logic          instr_valid_i;
  logic          instr_ready_o;
  logic          use_rs1_i;
  logic          use_rs2_i;
  logic [CW-1:0] vl_words_i;
  logic          agu_load_o;
  logic          agu_get_rs1_o;
  logic          agu_get_rs2_o;
  logic          agu_get_rd_o;
  logic          agu_incr_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] op_a_o;
  logic [DW-1:0] op_b_o;
  logic [DW-1:0] alu_result_i;
  logic          busy_o;
  logic          done_o;

  vcve2_vrf_seq dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .use_rs1_i     (use_rs1_i),
    .use_rs2_i     (use_rs2_i),
    .vl_words_i    (vl_words_i),
    .agu_load_o    (agu_load_o),
    .agu_get_rs1_o (agu_get_rs1_o),
    .agu_get_rs2_o (agu_get_rs2_o),
    .agu_get_rd_o  (agu_get_rd_o),
    .agu_incr_o    (agu_incr_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_wdata_o   (mem_wdata_o),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .alu_result_i  (alu_result_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // ALU stand-in: element-wise add of the two operand words.
  assign alu_result_i = op_a_o + op_b_o;

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- shared bench state ----------------
  int            n_vec;
  int            n_err;
  int            gnt_delay;
  int            rv_delay;
  bit            spurious;
  logic [31:0]   base_a1, base_a2, base_d;
  logic [31:0]   agu_rs1, agu_rs2, agu_rd;
  logic [DW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_wdata_q[$];
  logic [DW-1:0] mdl_a, mdl_b;
  int            n_load, n_req, n_rd_gnt;

  // Memory contents: a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- memory responder + AGU model ----------------
  initial begin : responder
    bit          rv_pending;
    int          rv_wait;
    logic [31:0] rv_data;
    int          wait_cnt;
    bit          hold_active;
    logic [2:0]  held_sel;
    logic        held_we;
    logic [31:0] held_wdata;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] exp_v;
    rv_pending  = 1'b0;
    rv_wait     = 0;
    rv_data     = '0;
    wait_cnt    = 0;
    hold_active = 1'b0;
    held_sel    = '0;
    held_we     = 1'b0;
    held_wdata  = '0;
    mem_gnt_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (!rst_ni) begin
        rv_pending  = 1'b0;
        hold_active = 1'b0;
        wait_cnt    = 0;
        continue;
      end
      if (agu_load_o) begin
        agu_rs1 = base_a1;
        agu_rs2 = base_a2;
        agu_rd  = base_d;
        n_load++;
      end
      if (rv_pending) begin
        if (rv_wait == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rv_data;
          rv_pending   = 1'b0;
        end else begin
          rv_wait--;
        end
      end
      if (mem_req_o) begin
        n_req++;
        sel = {agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o};
        n_vec++;
        if (!$onehot(sel) || (mem_we_o !== agu_get_rd_o)) begin
          n_err++;
          $display("FAIL agu_select: get={rs1,rs2,rd}=%b we=%b, required one-hot with we==get_rd", sel, mem_we_o);
        end
        if (hold_active) begin
          n_vec++;
          if (sel !== held_sel || mem_we_o !== held_we || mem_wdata_o !== held_wdata) begin
            n_err++;
            $display("FAIL req_stable: sel=%b we=%b wdata=%h, required %b %b %h", sel, mem_we_o, mem_wdata_o,
                     held_sel, held_we, held_wdata);
          end
        end
        if (wait_cnt >= gnt_delay) begin
          mem_gnt_i   = 1'b1;
          wait_cnt    = 0;
          hold_active = 1'b0;
          addr = sel[2] ? agu_rs1 : (sel[1] ? agu_rs2 : agu_rd);
          n_vec++;
          if (exp_addr_q.size() == 0) begin
            n_err++;
            $display("FAIL mem_addr: unexpected transaction at %h, required none", addr);
          end else begin
            exp_v = exp_addr_q.pop_front();
            if (addr !== exp_v) begin
              n_err++;
              $display("FAIL mem_addr: got %h, required %h", addr, exp_v);
            end
          end
          if (mem_we_o) begin
            n_vec++;
            if (exp_wdata_q.size() == 0) begin
              n_err++;
              $display("FAIL mem_wdata: unexpected write %h, required none", mem_wdata_o);
            end else begin
              exp_v = exp_wdata_q.pop_front();
              if (mem_wdata_o !== exp_v) begin
                n_err++;
                $display("FAIL mem_wdata: got %h, required %h", mem_wdata_o, exp_v);
              end
            end
          end else begin
            rv_pending = 1'b1;
            rv_wait    = rv_delay;
            rv_data    = mem_word(addr);
            n_rd_gnt++;
          end
          if (sel[2]) agu_rs1 = agu_rs1 + 32'd4;
          if (sel[1]) agu_rs2 = agu_rs2 + 32'd4;
          if (sel[0]) agu_rd  = agu_rd + 32'd4;
        end else begin
          wait_cnt++;
          if (!hold_active) begin
            hold_active = 1'b1;
            held_sel    = sel;
            held_we     = mem_we_o;
            held_wdata  = mem_wdata_o;
          end
        end
        if (spurious && mem_we_o) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = 32'hBAD0_BAD0;
        end
      end else if (hold_active) begin
        n_vec++;
        n_err++;
        $display("FAIL req_dropped: mem_req_o=0 before grant, required 1");
        hold_active = 1'b0;
      end
      #1;
      n_vec++;
      if (agu_incr_o !== (mem_req_o & mem_gnt_i)) begin
        n_err++;
        $display("FAIL agu_incr: got %b, required %b", agu_incr_o, mem_req_o & mem_gnt_i);
      end
    end
  end

  // ---------------- driver ----------------
  // Offer one instruction, hold it through the accepting edge, then drop valid.
  task automatic issue(input bit u1, input bit u2, input int vl);
    @(negedge clk_i);
    n_load   = 0;
    n_req    = 0;
    n_rd_gnt = 0;
    use_rs1_i     = u1;
    use_rs2_i     = u2;
    vl_words_i    = CW'(vl);
    instr_valid_i = 1'b1;
    n_vec++;
    if (instr_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL instr_ready: got %b before accept, required 1", instr_ready_o);
    end
    @(posedge clk_i);
  endtask

  // Build the expected transaction stream for one instruction from its fields.
  task automatic build_expect(input bit u1, input bit u2, input int vl);
    for (int i = 0; i < vl; i++) begin
      if (u1) begin
        exp_addr_q.push_back(base_a1 + 32'(4 * i));
        mdl_a = mem_word(base_a1 + 32'(4 * i));
      end
      if (u2) begin
        exp_addr_q.push_back(base_a2 + 32'(4 * i));
        mdl_b = mem_word(base_a2 + 32'(4 * i));
      end
      exp_addr_q.push_back(base_d + 32'(4 * i));
      exp_wdata_q.push_back(mdl_a + mdl_b);
    end
  endtask

  // Run one complete instruction and check latency, operands and side effects.
  task automatic run_instr(input string name, input bit u1, input bit u2, input int vl,
                           input int gd, input int rd, input bit spur);
    int lat;
    int exp_lat;
    int per_word;
    gnt_delay = gd;
    rv_delay  = rd;
    spurious  = spur;
    base_a1   = $urandom & 32'h0000_FF00;
    base_a2   = ($urandom & 32'h0000_FF00) | 32'h0001_0000;
    base_d    = ($urandom & 32'h0000_FF00) | 32'h0002_0000;
    build_expect(u1, u2, vl);
    per_word = (1 + gd) + (u1 ? (2 + gd + rd) : 0) + (u2 ? (2 + gd + rd) : 0);
    exp_lat  = (vl == 0) ? 1 : 2 + vl * per_word;
    issue(u1, u2, vl);
    lat = 1;
    forever begin
      @(negedge clk_i);
      instr_valid_i = 1'b0;
      if (done_o === 1'b1) break;
      if (lat > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL %s timeout: no done_o within %0d cycles", name, lat);
        break;
      end
      @(posedge clk_i);
      lat++;
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (instr_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_state: ready=%b busy=%b, required 0 1", name, instr_ready_o, busy_o);
    end
    n_vec++;
    if (op_a_o !== mdl_a || op_b_o !== mdl_b) begin
      n_err++;
      $display("FAIL %s operands: a=%h b=%h, required %h %h", name, op_a_o, op_b_o, mdl_a, mdl_b);
    end
    n_vec++;
    if (exp_addr_q.size() != 0 || exp_wdata_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing_txn: %0d addr %0d wdata left, required 0 0", name,
               exp_addr_q.size(), exp_wdata_q.size());
    end
    n_vec++;
    if (n_load != ((vl > 0) ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s agu_load_count: got %0d, required %0d", name, n_load, (vl > 0) ? 1 : 0);
    end
    @(negedge clk_i);
    n_vec++;
    if (done_o !== 1'b0 || instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: done=%b ready=%b busy=%b, required 0 1 0", name, done_o,
               instr_ready_o, busy_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_ni        = 1'b0;
    instr_valid_i = 1'b0;
    use_rs1_i     = 1'b0;
    use_rs2_i     = 1'b0;
    vl_words_i    = '0;
    gnt_delay     = 0;
    rv_delay      = 0;
    spurious      = 1'b0;
    mdl_a         = '0;
    mdl_b         = '0;
    repeat (3) @(negedge clk_i);
    #1;
    n_vec++;
    if (instr_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: ready=%b busy=%b done=%b, required 1 0 0", instr_ready_o, busy_o, done_o);
    end
    n_vec++;
    if ({mem_req_o, mem_we_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_incr_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: req/we/load/get/incr not all 0");
    end
    n_vec++;
    if (op_a_o !== '0 || op_b_o !== '0 || mem_wdata_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: a=%h b=%h wdata=%h, required 0", op_a_o, op_b_o, mem_wdata_o);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_both_srcs;
    run_instr("both_vl2", 1'b1, 1'b1, 2, 0, 0, 1'b0);
  endtask

  task automatic test_rs2_only;
    logic [DW-1:0] a_before;
    a_before = op_a_o;
    run_instr("rs2_vl1", 1'b0, 1'b1, 1, 0, 0, 1'b0);
    n_vec++;
    if (op_a_o !== a_before) begin
      n_err++;
      $display("FAIL rs2_vl1 op_a_held: got %h, required %h", op_a_o, a_before);
    end
  endtask

  task automatic test_vl_zero;
    run_instr("vl0", 1'b1, 1'b1, 0, 0, 0, 1'b0);
    n_vec++;
    if (n_req != 0) begin
      n_err++;
      $display("FAIL vl0 mem_req: %0d request cycles, required 0", n_req);
    end
  endtask

  task automatic test_gnt_delay;
    run_instr("gnt_delay3", 1'b1, 1'b0, 2, 3, 0, 1'b0);
  endtask

  task automatic test_rvalid_delay;
    run_instr("rvalid_delay2", 1'b1, 1'b0, 3, 0, 2, 1'b1);
    run_instr("rvalid_both", 1'b1, 1'b1, 2, 1, 2, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_instr("b2b_0", 1'b1, 1'b1, 1, 0, 0, 1'b0);
    run_instr("b2b_1", 1'b0, 1'b1, 2, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    bit u1, u2;
    int vl;
    for (int k = 0; k < 8; k++) begin
      u1 = 1'($urandom_range(0, 1));
      u2 = u1 ? 1'($urandom_range(0, 1)) : 1'b1;
      vl = $urandom_range(0, 8);
      run_instr("random", u1, u2, vl, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_op;
    int guard;
    gnt_delay = 0;
    rv_delay  = 3;
    spurious  = 1'b0;
    base_a1   = 32'h0000_1000;
    base_a2   = 32'h0001_2000;
    base_d    = 32'h0002_3000;
    build_expect(1'b1, 1'b1, 8);
    issue(1'b1, 1'b1, 8);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    guard = 0;
    // The sixth read grant is vs2 of word 3, so the sequencer is then waiting in W2.
    while (n_rd_gnt < 6 && guard < 500) begin
      @(negedge clk_i);
      guard++;
    end
    n_vec++;
    if (n_rd_gnt < 6) begin
      n_err++;
      $display("FAIL midrst timeout: %0d read grants, required 6", n_rd_gnt);
    end
    @(negedge clk_i);
    #2;
    n_vec++;
    if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst in_w2: busy=%b req=%b, required 1 0", busy_o, mem_req_o);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || instr_ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst status: req=%b busy=%b ready=%b done=%b, required 0 0 1 0", mem_req_o, busy_o,
               instr_ready_o, done_o);
    end
    n_vec++;
    if (op_a_o !== '0 || op_b_o !== '0 || agu_load_o !== 1'b0 || agu_incr_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst data: a=%h b=%h load=%b incr=%b, required 0", op_a_o, op_b_o, agu_load_o, agu_incr_o);
    end
    exp_addr_q.delete();
    exp_wdata_q.delete();
    mdl_a = '0;
    mdl_b = '0;
    repeat (2) @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    run_instr("after_midrst", 1'b1, 1'b1, 2, 0, 0, 1'b0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_load   = 0;
    n_req    = 0;
    n_rd_gnt = 0;
    agu_rs1  = '0;
    agu_rs2  = '0;
    agu_rd   = '0;
    base_a1  = '0;
    base_a2  = '0;
    base_d   = '0;
    test_reset();
    test_both_srcs();
    test_rs2_only();
    test_vl_zero();
    test_gnt_delay();
    test_rvalid_delay();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
